// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator gate line: transmitter frame states and receiver gate states.
// Also provides the receiver gate next-state rule used by the optional shadow FSM.
package acc_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_OPEN   = 3'd1;
    localparam logic [2:0] ST_HOLD   = 3'd2;
    localparam logic [2:0] ST_CLOSE  = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    localparam logic [1:0] RX_S0 = 2'b00;
    localparam logic [1:0] RX_S1 = 2'b01;
    localparam logic [1:0] RX_S2 = 2'b10;

    // S2 holds on a repeated 1; only a 0 returns it to S0.
    function automatic logic [1:0] rx_next(input logic [1:0] state, input logic line);
        logic [1:0] nxt;
        nxt = RX_S0;
        case (state)
            RX_S0:   nxt = line ? RX_S1 : RX_S0;
            RX_S1:   nxt = line ? RX_S2 : RX_S1;
            RX_S2:   nxt = line ? RX_S2 : RX_S0;
            default: nxt = RX_S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/acc_len_counter.sv
// Loadable down-counter holding the remaining gap length of a gate frame.
// Saturates at zero so a stray decrement can never wrap.
module acc_len_counter #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_cnt_is_one,
    output logic             o_cnt_is_zero
);

    logic [LEN_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

    assign o_cnt_is_zero = (r_cnt == '0);
    assign o_cnt_is_one  = (r_cnt == LEN_W'(1));

endmodule

// File: rtl/acc_window_tx.sv
// Frame generator for the accumulator gate line: emits 1, 0 x (LEN-1), 1, 0 so the receiver gate
// stays high for exactly LEN cycles. Optional shadow receiver enabled by ACC_TX_MIRROR_EN.
module acc_window_tx
    import acc_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_tx
`ifdef ACC_TX_MIRROR_EN
    ,
    output logic             o_win_mirror
`endif
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic       w_load;
    logic       w_dec;
    logic       w_cnt_is_one;
    logic       w_cnt_is_zero;

    assign w_load = (r_state == ST_IDLE) && i_start && (i_len != '0);
    assign w_dec  = (r_state == ST_HOLD);

    acc_len_counter #(
        .LEN_W (LEN_W)
    ) u_len_counter (
        .clk           (clk),
        .clr_n         (clr_n),
        .i_load        (w_load),
        .i_load_val    (i_len - LEN_W'(1)),
        .i_dec         (w_dec),
        .o_cnt_is_one  (w_cnt_is_one),
        .o_cnt_is_zero (w_cnt_is_zero)
    );

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next = w_load ? ST_OPEN : ST_IDLE;
            ST_OPEN:   w_next = w_cnt_is_zero ? ST_CLOSE : ST_HOLD;
            ST_HOLD:   w_next = w_cnt_is_one ? ST_CLOSE : ST_HOLD;
            ST_CLOSE:  w_next = ST_SETTLE;
            ST_SETTLE: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each one is valid for the whole state cycle.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tx    <= (w_next == ST_OPEN) || (w_next == ST_CLOSE);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_SETTLE);
            r_err   <= (r_state == ST_IDLE) && i_start && (i_len == '0);
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;

`ifdef ACC_TX_MIRROR_EN
    logic [1:0] r_rx_state;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_rx_state <= RX_S0;
        end else begin
            r_rx_state <= rx_next(r_rx_state, r_tx);
        end
    end

    assign o_win_mirror = (r_rx_state == RX_S1);
`endif

endmodule

// File: tb/tb_acc_window_tx.sv
// Bench for acc_window_tx: directed vector table, hand sequences and random frames checked against
// a frame-timing model. Compares win_mirror as well when ACC_TX_MIRROR_EN is defined.
module tb_acc_window_tx;

    localparam int LEN_W = 8;
    localparam int MAXC  = 4096;

    logic             clk = 1'b0;
    logic             clr_n = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, err, tx;
`ifdef ACC_TX_MIRROR_EN
    logic             win_mirror;
`endif

    always #5 clk = ~clk;

    acc_window_tx #(
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .i_start      (start),
        .i_len        (len),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_tx         (tx)
`ifdef ACC_TX_MIRROR_EN
        ,
        .o_win_mirror (win_mirror)
`endif
    );

    // Receiver gate FSM on the far end of the line, sharing clr_n.
    logic [1:0] rx_q;
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) rx_q <= 2'd0;
        else begin
            case (rx_q)
                2'd0:    rx_q <= tx ? 2'd1 : 2'd0;
                2'd1:    rx_q <= tx ? 2'd2 : 2'd1;
                2'd2:    rx_q <= tx ? 2'd2 : 2'd0;
                default: rx_q <= 2'd0;
            endcase
        end
    end
    wire gate = (rx_q == 2'd1);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int idle_from = 0;
    int done_seen = 0;
    int gate_seen = 0;

    bit m_tx[MAXC], m_busy[MAXC], m_done[MAXC], m_err[MAXC], m_gate[MAXC];

    typedef struct {
        bit s; int l;
        bit tx; bit busy; bit done; bit err; bit gate;
    } vec_t;
    vec_t vec[13];

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MAXC; i++) begin
            m_tx[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0; m_gate[i] = 0;
        end
        cyc = 0;
        idle_from = 0;
    endtask

    // A frame accepted at the end of cycle c: tx high at c+1 and c+1+L, gate c+2..c+1+L.
    task automatic model_accept(input bit s, input int l);
        if (s && cyc >= idle_from) begin
            if (l == 0) m_err[cyc+1] = 1;
            else begin
                m_tx[cyc+1] = 1;
                m_tx[cyc+1+l] = 1;
                for (int i = cyc + 1; i <= cyc + 2 + l; i++) m_busy[i] = 1;
                m_done[cyc+2+l] = 1;
                for (int i = cyc + 2; i <= cyc + 1 + l; i++) m_gate[i] = 1;
                idle_from = cyc + 3 + l;
            end
        end
    endtask

    task automatic step(input bit s, input int l);
        check("tx", tx, m_tx[cyc]);
        check("busy", busy, m_busy[cyc]);
        check("done", done, m_done[cyc]);
        check("err", err, m_err[cyc]);
        check("gate", gate, m_gate[cyc]);
`ifdef ACC_TX_MIRROR_EN
        check("win_mirror", win_mirror, m_gate[cyc]);
`endif
        if (done === 1'b1) done_seen++;
        if (gate === 1'b1) gate_seen++;
        start = s;
        len   = l[LEN_W-1:0];
        model_accept(s, l);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset takes effect before any clock edge; outputs checked while clr_n is still low.
    task automatic do_reset();
        clr_n = 1'b0;
        start = 1'b0;
        #1;
        check("rst_tx", tx, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_gate", gate, 1'b0);
`ifdef ACC_TX_MIRROR_EN
        check("rst_mirror", win_mirror, 1'b0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        model_clear();
    endtask

    initial begin
        // start, len, tx, busy, done, err, gate (outputs seen in the cycle the inputs are applied)
        vec[0]  = '{1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[3]  = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[4]  = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[5]  = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[6]  = '{1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[7]  = '{1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[8]  = '{1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[9]  = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[10] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vec[11] = '{1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[12] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        #2;
        do_reset();

        // Directed table: len=4 frame, len=0 error, len=1 frame.
        for (int i = 0; i < 13; i++) begin
            check("vec_tx", tx, vec[i].tx);
            check("vec_busy", busy, vec[i].busy);
            check("vec_done", done, vec[i].done);
            check("vec_err", err, vec[i].err);
            check("vec_gate", gate, vec[i].gate);
            start = vec[i].s;
            len   = vec[i].l[LEN_W-1:0];
            @(posedge clk);
            #1;
        end

        // start during HOLD ignored; then start held high with len=2.
        do_reset();
        done_seen = 0;
        step(1'b1, 5);
        step(1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 9);
        for (int i = 0; i < 5; i++) step(1'b0, 0);
        check_int("single_done_len5", done_seen, 1);
        for (int i = 0; i < 22; i++) step(1'b1, 2);
        for (int i = 0; i < 6; i++) step(1'b0, 0);

        // Reset in the middle of a long frame, then a clean len=3 window.
        do_reset();
        step(1'b1, 200);
        for (int i = 0; i < 20; i++) step(1'b0, 0);
        do_reset();
        gate_seen = 0;
        step(1'b0, 0);
        step(1'b1, 3);
        for (int i = 0; i < 8; i++) step(1'b0, 0);
        check_int("gate_len3", gate_seen, 3);

        // Maximum length window.
        do_reset();
        gate_seen = 0;
        step(1'b1, 255);
        for (int i = 0; i < 262; i++) step(1'b0, 0);
        check_int("gate_len255", gate_seen, 255);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            int l;
            r = int'($urandom_range(0, 9));
            if (r < 2) l = 0;
            else if (r < 8) l = int'($urandom_range(1, 12));
            else l = int'($urandom_range(13, 60));
            step($urandom_range(0, 2) == 0, l);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
